// File: rtl/rs_branch_pkg.sv
// rs_pkg: shared types and helpers for the branch reservation station.
//   TAG_NONE   - tag value meaning "operand already valid / no broadcast"
//   cdb_t      - common data bus broadcast {tag, value}
//   rs_entry_t - one reservation-station slot
//   rs_wakeup  - applies a CDB broadcast to both operands of an entry
package rs_pkg;

    localparam logic [5:0] TAG_NONE = 6'd0;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] value;
    } cdb_t;

    typedef struct packed {
        logic        valid;
        logic [9:0]  inst;
        logic [5:0]  dest;
        logic [5:0]  tag1;
        logic [31:0] val1;
        logic [5:0]  tag2;
        logic [31:0] val2;
        logic [31:0] addr;
    } rs_entry_t;

    // A zero tag never matches, so an idle bus (tag 0) leaves entries untouched.
    function automatic rs_entry_t rs_wakeup(input rs_entry_t e, input cdb_t c);
        rs_entry_t r;
        r = e;
        if (e.tag1 != TAG_NONE && e.tag1 == c.tag) begin
            r.val1 = c.value;
            r.tag1 = TAG_NONE;
        end
        if (e.tag2 != TAG_NONE && e.tag2 == c.tag) begin
            r.val2 = c.value;
            r.tag2 = TAG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_branch_if.sv
// rs_branch_if: dispatch, CDB and issue signals of the branch reservation station.
//   dispatch_*  - micro-op presented by dispatch (valid, inst, dest, tags, values, addr)
//   cdb         - {tag, value} broadcast, tag 0 = idle
//   full        - station cannot accept a dispatch
//   en / rs2exe - registered issue to the branch/jump executor
// modport master: the dispatch/CDB side; modport slave: the reservation station.
interface rs_branch_if #(parameter int TAG_W = 6);
    logic              dispatch_valid;
    logic [9:0]        dispatch_inst;
    logic [5:0]        dispatch_dest;
    logic [5:0]        dispatch_tag1;
    logic [5:0]        dispatch_tag2;
    logic [31:0]       dispatch_val1;
    logic [31:0]       dispatch_val2;
    logic [31:0]       dispatch_addr;
    logic [TAG_W+31:0] cdb;
    logic              full;
    logic              en;
    logic [111:0]      rs2exe;

    modport master (
        output dispatch_valid, dispatch_inst, dispatch_dest, dispatch_tag1,
               dispatch_tag2, dispatch_val1, dispatch_val2, dispatch_addr, cdb,
        input  full, en, rs2exe
    );

    modport slave (
        input  dispatch_valid, dispatch_inst, dispatch_dest, dispatch_tag1,
               dispatch_tag2, dispatch_val1, dispatch_val2, dispatch_addr, cdb,
        output full, en, rs2exe
    );
endinterface

// File: rtl/rs_branch_pick_oldest.sv
// rs_pick_oldest: fixed-priority encoder, index 0 (oldest) wins.
//   ready - per-entry ready vector
//   grant - one-hot grant of the lowest-index ready entry
//   found - at least one entry is ready
module rs_pick_oldest #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant,
    output logic             found
);
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rs_branch.sv
// rs_branch: reservation station + oldest-first issue for the branch/jump unit.
//   clk   - clock
//   reset - synchronous active-high reset (also clears rs2exe)
//   flush - synchronous clear of all entries and the issue valid
//   bus   - rs_branch_if.slave: dispatch, CDB snoop, full, en/rs2exe issue
// Entries form a shifting queue: index 0 is oldest, occupied slots are contiguous.
module rs_branch
    import rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    rs_branch_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    rs_entry_t        q     [DEPTH];
    rs_entry_t        q_nxt [DEPTH];
    rs_entry_t        woke  [DEPTH];
    rs_entry_t        disp_e;
    cdb_t             cdb_in;
    logic [DEPTH-1:0] ready, grant, sh;
    logic             found, accept;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [111:0]     iss_bus;
    logic             full_p1, en_p1;
    logic [111:0]     rs2exe_p1;

    assign cdb_in.tag   = bus.cdb[32 +: TAG_W];
    assign cdb_in.value = bus.cdb[31:0];

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ready[i] = q[i].valid && q[i].tag1 == TAG_NONE && q[i].tag2 == TAG_NONE;
    end

    rs_pick_oldest #(.DEPTH(DEPTH)) u_pick (
        .ready (ready),
        .grant (grant),
        .found (found)
    );

    // Conservative full: a slot freed by this cycle's issue is not reused.
    assign accept = bus.dispatch_valid & ~full_p1 & ~flush;

    // Incoming micro-op with CDB forwarding for a same-cycle broadcast.
    always_comb begin
        disp_e.valid = 1'b1;
        disp_e.inst  = bus.dispatch_inst;
        disp_e.dest  = bus.dispatch_dest;
        disp_e.tag1  = bus.dispatch_tag1;
        disp_e.val1  = bus.dispatch_val1;
        disp_e.tag2  = bus.dispatch_tag2;
        disp_e.val2  = bus.dispatch_val2;
        disp_e.addr  = bus.dispatch_addr;
        disp_e       = rs_wakeup(disp_e, cdb_in);
    end

    always_comb begin
        iss_bus = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = rs_wakeup(q[i], cdb_in);
            // sh[i]: entry i is at or above the issued slot and must move down.
            sh[i] = (i == 0) ? grant[0] : (sh[i-1] | grant[i]);
            if (grant[i])
                iss_bus = {q[i].inst, q[i].dest, q[i].val1, q[i].val2, q[i].addr};
        end
        for (int i = 0; i < DEPTH - 1; i++)
            q_nxt[i] = sh[i] ? woke[i+1] : woke[i];
        q_nxt[DEPTH-1] = sh[DEPTH-1] ? '0 : woke[DEPTH-1];
        // After the shift the first free slot is count-1 when an issue happened.
        if (accept) begin
            for (int i = 0; i < DEPTH; i++)
                if (i == int'(cnt) - int'(found))
                    q_nxt[i] = disp_e;
        end
        cnt_nxt = cnt + CW'(accept) - CW'(found);
    end

    // ---- stage p1: entry array, count and issue register ----
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cnt     <= '0;
            full_p1 <= 1'b0;
            en_p1   <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                q[i].valid <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            full_p1 <= (cnt_nxt == CW'(DEPTH));
            en_p1   <= found;
            q       <= q_nxt;
        end
    end

    // rs2exe holds its last value while nothing issues.
    always_ff @(posedge clk) begin
        if (reset)
            rs2exe_p1 <= '0;
        else if (found && !flush)
            rs2exe_p1 <= iss_bus;
    end

    assign bus.full   = full_p1;
    assign bus.en     = en_p1;
    assign bus.rs2exe = rs2exe_p1;

endmodule

// File: doc/rs_branch.md
# rs_branch

Reservation station and issue scheduler for the branch/jump execution unit. Holds up to `DEPTH` dispatched branch, JAL and JALR micro-ops and snoops the common data bus (CDB) until both operands are available. Each cycle it issues at most one ready micro-op, oldest first, as a registered `en`/`rs2exe` pair into the branch/jump executor. It sits between dispatch and the executor and is cleared by a pipeline flush.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries, range 2..16.
- `TAG_W`, default 6: ROB/register tag width. Tag 0 means "no tag / value valid".

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of all entries and the issue register; dominates dispatch.
- `dispatch_valid`  in  1  a new micro-op is presented this cycle.
- `dispatch_inst`  in  10  opcode class [9:3] and funct3 [2:0], as consumed by the executor.
- `dispatch_dest`  in  6  destination tag.
- `dispatch_tag1`, `dispatch_tag2`  in  6 each  producer tags; 0 means the matching value is valid.
- `dispatch_val1`, `dispatch_val2`  in  32 each  operand values, used when the matching tag is 0.
- `dispatch_addr`  in  32  PC-relative target (branch) or link address (JAL/JALR).
- `cdb`  in  38  {tag[5:0], value[31:0]}; tag 0 means no broadcast.
- `full`  out  1  registered; high when count == DEPTH.
- `en`  out  1  registered issue valid to the executor.
- `rs2exe`  out  112  registered {inst[9:0], dest[5:0], opr1[31:0], opr2[31:0], addr[31:0]}.

## Operation
- Storage is a shifting queue. Entry 0 is the oldest; occupied entries are contiguous from index 0.
- An entry holds `valid`, inst, dest, tag1/val1, tag2/val2 and addr. It is ready when `valid` is set, tag1 == 0 and tag2 == 0.
- Dispatch is accepted when `dispatch_valid & ~full & ~flush`. The entry is written at index count, or at count-1 if an issue removes an entry in the same cycle.
- CDB wakeup, per stored entry and per operand: if the tag is nonzero and equals `cdb[37:32]`, store `cdb[31:0]` and clear the tag.
- Dispatch forwarding applies the same match to the incoming operands. This covers a producer broadcasting in the dispatch cycle.
- Issue selection is combinational over the stored state (pre-wakeup values). The lowest-index ready entry is chosen.
  - If one exists: `en` ← 1, `rs2exe` ← its fields, the entry is removed, and higher entries shift down by one.
  - Otherwise `en` ← 0. `rs2exe` holds its previous value and is don't-care while `en` is 0.
- Count updates by +dispatch −issue, so it is unchanged when both happen.
- `full` is computed from the next count.
- `flush`: all `valid` ← 0, count ← 0, `en` ← 0, `full` ← 0. Any dispatch in the flush cycle is dropped.
- Reset: identical to flush, and also `rs2exe` ← 0.

## Timing
- Dispatch at edge E0 with both tags 0 → `en` high in the cycle following edge E1. Minimum latency is 2 edges.
- CDB match at edge Ek → the entry becomes selectable in cycle k+1 and issues at edge Ek+1.
- No same-cycle CDB→issue bypass.
- Throughput: 1 issue per cycle. The executor is always ready, so there is no backpressure on `en`.
- `full` is conservative: when full, dispatch is refused even if an issue frees a slot that cycle.
- Full at DEPTH, empty at 0. No pointer wrap, because the queue shifts.
- Reset or flush asserted mid-operation takes effect at the next edge. `en` is low in the following cycle, regardless of what was ready.

## Structure
- Package `rs_pkg` contains:
  - `TAG_NONE` = 6'd0
  - typedef `cdb_t` {tag, value}
  - typedef `rs_entry_t` {valid, inst, dest, tag1, val1, tag2, val2, addr}
  - function `rs_wakeup(entry, cdb)` returning the updated entry.
- Sub-module `rs_pick_oldest`: a DEPTH-wide priority encoder producing a one-hot grant and a found flag from the ready vector.
- The top level holds the entry array, shift/insert logic, count and issue register.

## Test plan
- Reset then dispatch BEQ (inst 10'b0000000_000), tags 0, val1 = val2 = 5, dest 3 → `en` = 1 exactly two edges later; `rs2exe` = {inst, 6'd3, 32'd5, 32'd5, addr}; `full` = 0.
- Dispatch BLT with tag1 = 7, then drive `cdb` = {6'd7, 32'hFFFF_FFFF} three cycles later → no issue before the wakeup; `en` one edge after the CDB edge; opr1 = 32'hFFFF_FFFF.
- Dispatch JAL whose tag2 = 9 in the same cycle that `cdb` carries tag 9, value 100 → forwarded; issues with opr2 = 100.
- Fill DEPTH = 4 entries with all operands waiting; `full` = 1; the 5th dispatch is ignored. Wake entry 2 then entry 0 in the same cycle → entry 0 issues first, entry 2 on the next cycle, and count drops 4→3→2.
- With 3 ready entries queued, assert `flush` together with `dispatch_valid` → next cycle `en` = 0, `full` = 0, and no further issues.
- Assert `reset` mid-stream while `en` = 1 → next cycle `en` = 0, `rs2exe` = 0, and the queue is empty.
